load_store_unit: RTL

Sits between the pipeline MEM stage and `dmemory`. It translates RISC-V load/store funct3 codes into the memory's `ByteAccess` encoding and sign-extends load results, which `dmemory` returns zero-extended. Misaligned halfword and word accesses are split into sequential byte transactions, and the pipeline is stalled until the access completes. Aligned accesses complete in a single cycle with no stall.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/load_store_unit_load_extend.sv | 21 ++
 rtl/load_store_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
package lsu_pkg;

  // RISC-V load/store funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size as encoded in funct3[1:0]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // dmemory ByteAccess encoding
  localparam logic [1:0] BA_WORD = 2'b00;
  localparam logic [1:0] BA_BYTE = 2'b01;
  localparam logic [1:0] BA_HALF = 2'b10;

  typedef enum logic {IDLE, SPLIT} lsu_state_t;

  // Loads accept lb/lh/lw/lbu/lhu; stores accept only sb/sh/sw.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic write);
    if (write)
      return !((f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW));
    else
      return !((f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU));
  endfunction

  // Translate an access size into the memory's ByteAccess code.
  function automatic logic [1:0] size_to_ba(input logic [1:0] size);
    case (size)
      SZ_BYTE: return BA_BYTE;
      SZ_HALF: return BA_HALF;
      default: return BA_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Sign/zero extension of a right-aligned load result by access size.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  // Bits above the access size are ignored, so stale upper bytes are harmless.
  always_comb begin
    o_data = i_data;
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & i_data[7]}},  i_data[7:0]};
      SZ_HALF: o_data = {{16{~i_unsigned & i_data[15]}}, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and dmemory: funct3 decode,
// load extension, and splitting of misaligned accesses into byte cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        access_fault,
  output logic        mem_we,
  output logic [1:0]  mem_byte_access,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_asm;

  logic [1:0]  w_size;
  logic        w_illegal;
  logic        w_misaligned;
  logic [1:0]  w_last;
  logic        w_in_split;
  logic        w_start;
  logic        w_fault;
  logic        w_final;
  logic        w_bytewise;
  logic [1:0]  w_idx;
  logic [7:0]  w_byte;
  logic [31:0] w_assembled;
  logic [31:0] w_ext_in;
  logic [31:0] w_ext_out;

  assign w_size       = req_funct3[1:0];
  assign w_illegal    = f3_illegal(req_funct3, req_write);
  assign w_misaligned = ((w_size == SZ_HALF) && req_addr[0]) ||
                        ((w_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign w_last       = (w_size == SZ_HALF) ? 2'd1 : 2'd3;
  assign w_in_split   = (r_state == SPLIT);
  assign w_start      = (r_state == IDLE) && req_valid && !w_illegal &&
                        w_misaligned && (MISALIGNED != 0);
  assign w_fault      = (r_state == IDLE) && req_valid &&
                        (w_illegal || (w_misaligned && (MISALIGNED == 0)));
  assign w_final      = w_in_split && (r_cnt == w_last);
  assign w_bytewise   = w_start || w_in_split;
  // Byte 0 is issued from IDLE; later bytes are indexed by the counter.
  assign w_idx        = w_in_split ? r_cnt : 2'd0;
  assign w_byte       = req_wdata[{w_idx, 3'b000} +: 8];

  // Merge the byte arriving this cycle into the bytes collected so far.
  always_comb begin
    w_assembled = r_asm;
    w_assembled[{r_cnt, 3'b000} +: 8] = mem_rdata[7:0];
  end

  assign w_ext_in = w_final ? w_assembled : mem_rdata;

  load_extend u_load_extend (
    .i_data     (w_ext_in),
    .i_size     (w_size),
    .i_unsigned (req_funct3[2]),
    .o_data     (w_ext_out)
  );

  // Memory-side and pipeline-side outputs; reset forces the handshake quiet.
  always_comb begin
    stall           = reset_n & (w_start | (w_in_split & ~w_final));
    access_fault    = reset_n & w_fault;
    mem_we          = reset_n & (w_in_split ? req_write
                                            : (req_valid & req_write & ~w_fault));
    load_data       = reset_n ? w_ext_out : 32'h0;
    mem_addr        = req_addr + {30'h0, w_idx};
    mem_byte_access = w_bytewise ? BA_BYTE : size_to_ba(w_size);
    mem_wdata       = w_bytewise ? {24'h0, w_byte} : req_wdata;
  end

  // Split sequencer: walks the byte index and gathers load bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_asm   <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= SPLIT;
            r_cnt   <= 2'd1;
            r_asm   <= {24'h0, mem_rdata[7:0]};
          end
        end
        SPLIT: begin
          if (w_final) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
          end else begin
            r_cnt <= r_cnt + 2'd1;
            r_asm[{r_cnt, 3'b000} +: 8] <= mem_rdata[7:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
